// File: rtl/cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmp_arbiter
// Description : Two-requester arbiter for one shared comparator. It decodes
//               RISC-V funct3 compare ops, grants one requester per cycle
//               (round-robin or fixed priority) and keeps a one-entry
//               response slot for each requester.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_arbiter #(
    parameter int WIDTH      = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [1:0]       rsp_result,
    output logic [WIDTH-1:0] cmp_rs1d,
    output logic [WIDTH-1:0] cmp_rs2d,
    output logic             cmp_s,
    input  logic             cmp_eq,
    input  logic             cmp_lt
);

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    logic [1:0] slot_full;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       last_grant_q;
    logic       last_grant_d;
    logic [2:0] sel_op;
    logic       result_bit;

    // Signed compare for BLT, BGE and SLT; everything else is unsigned.
    function automatic logic op_signed(input logic [2:0] op);
        return (op == 3'b100) || (op == 3'b101) || (op == 3'b010);
    endfunction

    // Map comparator flags to the one-bit outcome of the op.
    function automatic logic op_result(input logic [2:0] op, input logic eq, input logic lt);
        logic r;
        case (op)
            3'b000:         r = eq;
            3'b001:         r = !eq;
            3'b101, 3'b111: r = !lt;
            default:        r = lt;     // BLT, SLT, BLTU, SLTU
        endcase
        return r;
    endfunction

    // A requester may go if its slot is free or is being drained this cycle.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            eligible[k] = req_valid[k] && (!slot_full[k] || rsp_ready[k]);
        end
    end

    // Single grant per cycle; a tie goes to the requester not served last.
    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            if ((FIXED_PRIO != 0) || last_grant_q) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end
        req_ready    = grant;
        last_grant_d = last_grant_q;
        if (grant[0]) begin
            last_grant_d = 1'b0;
        end else if (grant[1]) begin
            last_grant_d = 1'b1;
        end
    end

    // Steer the granted requester to the comparator; idle defaults to requester 0.
    always_comb begin
        cmp_rs1d = req0_a;
        cmp_rs2d = req0_b;
        cmp_s    = 1'b0;
        sel_op   = req0_op;
        if (grant[1]) begin
            cmp_rs1d = req1_a;
            cmp_rs2d = req1_b;
            cmp_s    = op_signed(req1_op);
            sel_op   = req1_op;
        end else if (grant[0]) begin
            cmp_s    = op_signed(req0_op);
        end
        result_bit = op_result(sel_op, cmp_eq, cmp_lt);
    end

    // Remember who was served last; reset value lets requester 0 win first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_slot
        slot_state_t state_q;
        slot_state_t state_d;
        logic        result_q;
        logic        result_d;

        // Slot next state: a grant always loads, a drain alone empties.
        always_comb begin
            state_d  = state_q;
            result_d = result_q;
            if (grant[k]) begin
                state_d  = SLOT_FULL;
                result_d = result_bit;
            end else if ((state_q == SLOT_FULL) && rsp_ready[k]) begin
                state_d  = SLOT_EMPTY;
            end
        end

        // Slot registers; reset discards any held response.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= SLOT_EMPTY;
                result_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                result_q <= result_d;
            end
        end

        assign slot_full[k]  = (state_q == SLOT_FULL);
        assign rsp_valid[k]  = slot_full[k];
        assign rsp_result[k] = result_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_arbiter
// Description : Self-checking bench for cmp_arbiter with a behavioural
//               comparator and per-requester result scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic [1:0]    req_valid, rsp_ready;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_op, req1_op;
    logic [1:0]    req_ready, rsp_valid, rsp_result;
    logic [W-1:0]  cmp_rs1d, cmp_rs2d;
    logic          cmp_s, cmp_eq, cmp_lt;
    logic [1:0]    f_req_ready, f_rsp_valid, f_rsp_result;
    logic [W-1:0]  f_cmp_rs1d, f_cmp_rs2d;
    logic          f_cmp_s, f_cmp_eq, f_cmp_lt;

    int checks   = 0;
    int failures = 0;
    bit sb [2][$];

    // Behavioural comparators
    assign cmp_eq   = (cmp_rs1d == cmp_rs2d);
    assign cmp_lt   = cmp_s ? ($signed(cmp_rs1d) < $signed(cmp_rs2d)) : (cmp_rs1d < cmp_rs2d);
    assign f_cmp_eq = (f_cmp_rs1d == f_cmp_rs2d);
    assign f_cmp_lt = f_cmp_s ? ($signed(f_cmp_rs1d) < $signed(f_cmp_rs2d)) : (f_cmp_rs1d < f_cmp_rs2d);

    cmp_arbiter #(.WIDTH(W), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .cmp_rs1d(cmp_rs1d), .cmp_rs2d(cmp_rs2d), .cmp_s(cmp_s),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt)
    );

    cmp_arbiter #(.WIDTH(W), .FIXED_PRIO(1)) u_dut_fixed (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(f_req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op), .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(f_rsp_result), .cmp_rs1d(f_cmp_rs1d), .cmp_rs2d(f_cmp_rs2d), .cmp_s(f_cmp_s),
        .cmp_eq(f_cmp_eq), .cmp_lt(f_cmp_lt)
    );

    // Reference result of a funct3 compare op
    function automatic bit model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit lts, ltu;
        lts = ($signed(a) < $signed(b));
        ltu = (a < b);
        case (op)
            3'b000:         return (a == b);
            3'b001:         return (a != b);
            3'b100, 3'b010: return lts;
            3'b101:         return !lts;
            3'b110, 3'b011: return ltu;
            default:        return !ltu;
        endcase
    endfunction

    // Reset both DUTs and empty the scoreboards; returns 1 time unit after a rising edge.
    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        sb[0].delete();
        sb[1].delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_op = 0; req1_op = 0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++;
        if (rsp_result !== 2'b00) begin failures++; $display("FAIL reset_rsp_result got=%b exp=00", rsp_result); end
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL reset_ready_both got=%b exp=01", req_ready); end
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL reset_ready_req1 got=%b exp=10", req_ready); end
        req_valid = 2'b00;
        sb[0].delete();
        sb[1].delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Requester 0 alone: BLT then BLTU on -1 vs 1
    task automatic test_single();
        logic [2:0] ops [2]  = '{3'b100, 3'b110};
        bit         exps [2] = '{1'b1, 1'b0};
        bit e;
        apply_reset();
        rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            req_valid = 2'b01; req0_op = ops[i]; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                checks++;
                if (req_ready !== (c == 0 ? 2'b01 : 2'b00)) begin
                    failures++; $display("FAIL single_ready op=%0d cyc=%0d got=%b", ops[i], c, req_ready);
                end
                if (c == 1) begin
                    checks++;
                    if (rsp_valid !== 2'b01 || rsp_result[0] !== exps[i]) begin
                        failures++;
                        $display("FAIL single_rsp op=%0d got valid=%b res=%b exp valid=01 res=%b", ops[i], rsp_valid, rsp_result[0], exps[i]);
                    end
                end
                for (int k = 0; k < 2; k++) begin
                    if (rsp_valid[k] && rsp_ready[k]) begin
                        checks++;
                        if (sb[k].size() == 0) begin failures++; $display("FAIL single_sb%0d unexpected got=%b", k, rsp_result[k]); end
                        else begin
                            e = sb[k].pop_front();
                            if (rsp_result[k] !== e) begin failures++; $display("FAIL single_sb%0d got=%b exp=%b", k, rsp_result[k], e); end
                        end
                    end
                end
                if (req_valid[0] && req_ready[0]) sb[0].push_back(model(req0_op, req0_a, req0_b));
                if (req_valid[1] && req_ready[1]) sb[1].push_back(model(req1_op, req1_a, req1_b));
                @(posedge clk); #1;
                req_valid = 2'b00;
            end
        end
    endtask

    // All ops on each requester with the other idle, operands chosen to split signed/unsigned
    task automatic test_ops();
        logic [W-1:0] pa [4] = '{32'd5, 32'hFFFF_FFFF, 32'h1, 32'd7};
        logic [W-1:0] pb [4] = '{32'd5, 32'h1, 32'hFFFF_FFFF, 32'd3};
        bit e;
        apply_reset();
        rsp_ready = 2'b11;
        for (int n = 0; n <= 64; n++) begin
            int k = n / 32;
            int op = (n / 4) % 8;
            int p = n % 4;
            req0_op = (k == 0) ? 3'(op) : ~3'(op);
            req1_op = (k == 1) ? 3'(op) : ~3'(op);
            req0_a = (k == 0) ? pa[p] : pa[(p + 2) % 4];
            req0_b = (k == 0) ? pb[p] : pb[(p + 2) % 4];
            req1_a = (k == 1) ? pa[p] : pa[(p + 2) % 4];
            req1_b = (k == 1) ? pb[p] : pb[(p + 2) % 4];
            req_valid = (n == 64) ? 2'b00 : ((k == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
            checks++;
            if (req_ready !== req_valid) begin failures++; $display("FAIL ops_ready n=%0d got=%b exp=%b", n, req_ready, req_valid); end
            for (int j = 0; j < 2; j++) begin
                if (rsp_valid[j] && rsp_ready[j]) begin
                    checks++;
                    if (sb[j].size() == 0) begin failures++; $display("FAIL ops_sb%0d unexpected got=%b", j, rsp_result[j]); end
                    else begin
                        e = sb[j].pop_front();
                        if (rsp_result[j] !== e) begin failures++; $display("FAIL ops_sb%0d n=%0d got=%b exp=%b", j, n, rsp_result[j], e); end
                    end
                end
            end
            if (req_valid[0] && req_ready[0]) sb[0].push_back(model(req0_op, req0_a, req0_b));
            if (req_valid[1] && req_ready[1]) sb[1].push_back(model(req1_op, req1_a, req1_b));
            @(posedge clk); #1;
        end
        checks++;
        if (sb[0].size() + sb[1].size() != 0) begin failures++; $display("FAIL ops_drained left=%0d exp=0", sb[0].size() + sb[1].size()); end
    endtask

    // Both valid every cycle: grants alternate starting with requester 0
    task automatic test_round_robin();
        logic [1:0] exp_rdy;
        bit e;
        apply_reset();
        rsp_ready = 2'b11;
        req0_op = 3'b000; req0_a = 32'd5; req0_b = 32'd5;
        req1_op = 3'b011; req1_a = 32'd3; req1_b = 32'd7;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 6) ? 2'b11 : 2'b00;
            exp_rdy   = (c < 6) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            @(negedge clk);
            checks++;
            if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            for (int k = 0; k < 2; k++) begin
                if (rsp_valid[k] && rsp_ready[k]) begin
                    checks++;
                    if (sb[k].size() == 0) begin failures++; $display("FAIL rr_sb%0d unexpected got=%b", k, rsp_result[k]); end
                    else begin
                        e = sb[k].pop_front();
                        if (rsp_result[k] !== e) begin failures++; $display("FAIL rr_sb%0d got=%b exp=%b", k, rsp_result[k], e); end
                    end
                end
            end
            if (req_valid[0] && req_ready[0]) sb[0].push_back(model(req0_op, req0_a, req0_b));
            if (req_valid[1] && req_ready[1]) sb[1].push_back(model(req1_op, req1_a, req1_b));
            @(posedge clk); #1;
        end
        checks++;
        if (sb[0].size() + sb[1].size() != 0) begin failures++; $display("FAIL rr_drained left=%0d exp=0", sb[0].size() + sb[1].size()); end
    endtask

    // Slot 0 held full: requester 1 takes every grant, slot 0 result frozen
    task automatic test_backpressure();
        logic [1:0] vt [7] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
        logic [1:0] rt [7] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
        logic [1:0] et [7] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
        bit e;
        apply_reset();
        req0_op = 3'b100; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1;
        req1_op = 3'b010; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0;
        for (int c = 0; c < 7; c++) begin
            req_valid = vt[c];
            rsp_ready = rt[c];
            if (c == 1) begin req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd1; end
            @(negedge clk);
            checks++;
            if (req_ready !== et[c]) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", c, req_ready, et[c]); end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 1'b1) begin
                    failures++; $display("FAIL bp_hold cyc=%0d got valid=%b res=%b exp valid=1 res=1", c, rsp_valid[0], rsp_result[0]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (rsp_valid[k] && rsp_ready[k]) begin
                    checks++;
                    if (sb[k].size() == 0) begin failures++; $display("FAIL bp_sb%0d unexpected got=%b", k, rsp_result[k]); end
                    else begin
                        e = sb[k].pop_front();
                        if (rsp_result[k] !== e) begin failures++; $display("FAIL bp_sb%0d got=%b exp=%b", k, rsp_result[k], e); end
                    end
                end
            end
            if (req_valid[0] && req_ready[0]) sb[0].push_back(model(req0_op, req0_a, req0_b));
            if (req_valid[1] && req_ready[1]) sb[1].push_back(model(req1_op, req1_a, req1_b));
            @(posedge clk); #1;
        end
        checks++;
        if (sb[0].size() + sb[1].size() != 0) begin failures++; $display("FAIL bp_drained left=%0d exp=0", sb[0].size() + sb[1].size()); end
    endtask

    // Requester 1 drains and is re-granted in the same cycle
    task automatic test_drain_grant();
        logic [1:0] vt [4] = '{2'b10, 2'b10, 2'b00, 2'b00};
        logic [1:0] et [4] = '{2'b10, 2'b10, 2'b00, 2'b00};
        logic [1:0] st [4] = '{2'b00, 2'b10, 2'b10, 2'b00};
        bit e;
        apply_reset();
        rsp_ready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            req_valid = vt[c];
            if (c == 0) begin req1_op = 3'b010; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0; end
            else        begin req1_op = 3'b101; req1_a = 32'h0;         req1_b = 32'h0; end
            @(negedge clk);
            checks++;
            if (req_ready !== et[c] || rsp_valid !== st[c]) begin
                failures++; $display("FAIL dg_state cyc=%0d got ready=%b valid=%b exp ready=%b valid=%b", c, req_ready, rsp_valid, et[c], st[c]);
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (rsp_result[1] !== 1'b1) begin failures++; $display("FAIL dg_result cyc=%0d got=%b exp=1", c, rsp_result[1]); end
            end
            for (int k = 0; k < 2; k++) begin
                if (rsp_valid[k] && rsp_ready[k]) begin
                    checks++;
                    if (sb[k].size() == 0) begin failures++; $display("FAIL dg_sb%0d unexpected got=%b", k, rsp_result[k]); end
                    else begin
                        e = sb[k].pop_front();
                        if (rsp_result[k] !== e) begin failures++; $display("FAIL dg_sb%0d got=%b exp=%b", k, rsp_result[k], e); end
                    end
                end
            end
            if (req_valid[0] && req_ready[0]) sb[0].push_back(model(req0_op, req0_a, req0_b));
            if (req_valid[1] && req_ready[1]) sb[1].push_back(model(req1_op, req1_a, req1_b));
            @(posedge clk); #1;
        end
    endtask

    // Fixed-priority instance: requester 0 always wins, requester 1 starves
    task automatic test_fixed_prio();
        bit e;
        apply_reset();
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        req0_op = 3'b111; req0_a = 32'd2; req0_b = 32'd3;
        req1_op = 3'b010; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0;
        e = model(req0_op, req0_a, req0_b);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (f_req_ready !== 2'b01) begin failures++; $display("FAIL fixed_ready cyc=%0d got=%b exp=01", c, f_req_ready); end
            if (c > 0) begin
                checks++;
                if (f_rsp_valid !== 2'b01 || f_rsp_result[0] !== e) begin
                    failures++; $display("FAIL fixed_rsp cyc=%0d got valid=%b res=%b exp valid=01 res=%b", c, f_rsp_valid, f_rsp_result[0], e);
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
    endtask

    // Asynchronous reset while slot 1 is full
    task automatic test_reset_midop();
        apply_reset();
        rsp_ready = 2'b00;
        req_valid = 2'b10; req1_op = 3'b011; req1_a = 32'd3; req1_b = 32'd7;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL mid_grant1 got=%b exp=10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b01; req0_op = 3'b000; req0_a = 32'd4; req0_b = 32'd4;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_grant0 got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b11) begin failures++; $display("FAIL mid_full got=%b exp=11", rsp_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || rsp_result !== 2'b00) begin
            failures++; $display("FAIL mid_async got valid=%b res=%b exp valid=00 res=00", rsp_valid, rsp_result);
        end
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        @(posedge clk); #1 reset_n = 1'b1;
        sb[0].delete();
        sb[1].delete();
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_first_grant got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || rsp_result[0] !== 1'b1) begin
            failures++; $display("FAIL mid_after got valid=%b res=%b exp valid=01 res=1", rsp_valid, rsp_result[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_drain_grant();
        test_fixed_prio();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
